// File: rtl/fpu_dispatch.sv
// Issue stage for the single-precision FPU core: owns the f0..f31 register file,
// dispatches one instruction at a time, writes the result back and watches for a hung core.
module fpu_dispatch #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    input  logic        ld_en,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [31:0] fpu_A,
    output logic [31:0] fpu_B,
    output logic [1:0]  fpu_op,
    output logic        fpu_start,
    input  logic [31:0] fpu_R,
    input  logic        fpu_done,
    output logic        resp_valid,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        timeout_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   regs [32];
    logic [TW-1:0] cnt;
    logic [1:0]    op_q;
    logic [4:0]    rd_q;
    logic [31:0]   res_q;
    logic [31:0]   opa;
    logic [31:0]   opb;
    logic          accept;
    logic          timeout_hit;

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, so the issuer holds its request until then.
    assign accept      = (state == S_IDLE) && req_valid;
    assign timeout_hit = (state == S_WAIT) && !fpu_done && (cnt == TW'(TIMEOUT - 1));

    // A load landing in the accept cycle is forwarded so the op sees the new value.
    assign opa = (ld_en && (ld_addr == req_rs1)) ? ld_data : regs[req_rs1];
    assign opb = (ld_en && (ld_addr == req_rs2)) ? ld_data : regs[req_rs2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (fpu_done) begin
                    state_nxt = S_WRITE;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_A       <= '0;
            fpu_B       <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            res_q       <= '0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            // Operands are only loaded on accept, so they stay stable until IDLE.
            if (accept) begin
                fpu_A <= opa;
                fpu_B <= opb;
                op_q  <= req_op;
                rd_q  <= req_rd;
            end
            if (state == S_ISSUE) begin
                cnt <= '0;
            end else if ((state == S_WAIT) && !fpu_done) begin
                cnt <= cnt + 1'b1;
            end
            if ((state == S_WAIT) && fpu_done) begin
                res_q <= fpu_R;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // The write-back is placed after the load so it wins on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            if (state == S_WRITE) begin
                regs[rd_q] <= res_q;
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign fpu_start  = (state == S_ISSUE);
    assign fpu_op     = op_q;
    assign resp_valid = (state == S_WRITE);
    assign resp_rd    = rd_q;
    assign resp_data  = res_q;
    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch: the bench plays the FPU core, checks operands on every
// start pulse and every write-back response against queues filled when stimulus is driven.
module tb_fpu_dispatch;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [4:0]  req_rd;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] fpu_A;
  logic [31:0] fpu_B;
  logic [1:0]  fpu_op;
  logic        fpu_start;
  logic [31:0] fpu_R;
  logic        fpu_done;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int n_issued = 0;
  int start_seen = 0;

  logic [65:0] start_q[$];
  logic [36:0] resp_q[$];

  fpu_dispatch #(.TIMEOUT(8), .TW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .fpu_A(fpu_A), .fpu_B(fpu_B), .fpu_op(fpu_op), .fpu_start(fpu_start),
    .fpu_R(fpu_R), .fpu_done(fpu_done),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
    .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic ld(input logic [4:0] addr, input logic [31:0] data);
    ld_en = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] ea, input logic [31:0] eb,
                       input logic byp_en, input logic [4:0] byp_addr, input logic [31:0] byp_data);
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    chk("ready_before_issue", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_op = op;
    req_rs1 = rs1;
    req_rs2 = rs2;
    req_rd = rd;
    ld_en = byp_en;
    ld_addr = byp_addr;
    ld_data = byp_data;
    start_q.push_back({op, ea, eb});
    n_issued++;
    tick();
    req_valid = 1'b0;
    ld_en = 1'b0;
    chk("issue_state", {62'd0, dbg_state}, 64'd1);
  endtask

  // Called in the ISSUE cycle; done is raised in WAIT cycle number 'delay'.
  task automatic complete(input int delay, input logic [4:0] rd, input logic [31:0] r,
                          input logic wl_en, input logic [4:0] wl_addr, input logic [31:0] wl_data);
    tick();
    repeat (delay) tick();
    fpu_done = 1'b1;
    fpu_R = r;
    resp_q.push_back({rd, r});
    tick();
    fpu_done = 1'b0;
    chk("write_resp_valid", {63'd0, resp_valid}, 64'd1);
    ld_en = wl_en;
    ld_addr = wl_addr;
    ld_data = wl_data;
    tick();
    ld_en = 1'b0;
    chk("idle_after_write", {63'd0, req_ready}, 64'd1);
  endtask

  // scoreboard
  initial begin
    logic [65:0] se;
    logic [36:0] re;
    forever begin
      @(negedge clk);
      if (fpu_start === 1'b1) begin
        start_seen++;
        if (start_q.size() == 0) begin
          chk("start_unexpected", 64'(start_q.size()), 64'd1);
        end else begin
          se = start_q.pop_front();
          chk("start_op", {62'd0, fpu_op}, {62'd0, se[65:64]});
          chk("start_A", {32'd0, fpu_A}, {32'd0, se[63:32]});
          chk("start_B", {32'd0, fpu_B}, {32'd0, se[31:0]});
        end
      end
      if (resp_valid === 1'b1) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 64'(resp_q.size()), 64'd1);
        end else begin
          re = resp_q.pop_front();
          chk("resp_rd", {59'd0, resp_rd}, {59'd0, re[36:32]});
          chk("resp_data", {32'd0, resp_data}, {32'd0, re[31:0]});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 2'd0;
    req_rs1 = 5'd0;
    req_rs2 = 5'd0;
    req_rd = 5'd0;
    ld_en = 1'b0;
    ld_addr = 5'd0;
    ld_data = 32'd0;
    fpu_R = 32'd0;
    fpu_done = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_start", {63'd0, fpu_start}, 64'd0);
    chk("rst_terr", {63'd0, timeout_err}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // reset in the middle of WAIT
    ld(5'd7, 32'h1111_1111);
    issue(2'b01, 5'd7, 5'd7, 5'd8, 32'h1111_1111, 32'h1111_1111, 1'b0, 5'd0, 32'd0);
    tick();
    tick();
    chk("pre_rst_wait", {62'd0, dbg_state}, 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_A", {32'd0, fpu_A}, 64'd0);
    chk("mid_rst_B", {32'd0, fpu_B}, 64'd0);
    chk("mid_rst_op", {62'd0, fpu_op}, 64'd0);
    chk("mid_rst_start", {63'd0, fpu_start}, 64'd0);
    chk("mid_rst_resp", {63'd0, resp_valid}, 64'd0);
    chk("mid_rst_rd", {59'd0, resp_rd}, 64'd0);
    chk("mid_rst_data", {32'd0, resp_data}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // f8 never written and f7 cleared by reset
    issue(2'b00, 5'd8, 5'd7, 5'd9, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    complete(0, 5'd9, 32'h0102_0304, 1'b0, 5'd0, 32'd0);

    // basic FADD
    ld(5'd1, 32'h3F00_0000);
    ld(5'd2, 32'hBEC0_0000);
    issue(2'b00, 5'd1, 5'd2, 5'd3, 32'h3F00_0000, 32'hBEC0_0000, 1'b0, 5'd0, 32'd0);
    complete(1, 5'd3, 32'h3E00_0000, 1'b0, 5'd0, 32'd0);
    chk("single_start", 64'(start_seen), 64'(n_issued));

    // minimum latency: done in the first WAIT cycle
    ld(5'd4, 32'h4010_0000);
    ld(5'd5, 32'h40D0_0000);
    issue(2'b00, 5'd4, 5'd5, 5'd6, 32'h4010_0000, 32'h40D0_0000, 1'b0, 5'd0, 32'd0);
    chk("lat_c1_resp", {63'd0, resp_valid}, 64'd0);
    tick();
    chk("lat_c2_state", {62'd0, dbg_state}, 64'd2);
    chk("lat_c2_resp", {63'd0, resp_valid}, 64'd0);
    fpu_done = 1'b1;
    fpu_R = 32'h410C_0000;
    resp_q.push_back({5'd6, 32'h410C_0000});
    tick();
    fpu_done = 1'b0;
    chk("lat_c3_resp", {63'd0, resp_valid}, 64'd1);
    tick();

    // done outside WAIT is ignored
    fpu_done = 1'b1;
    fpu_R = 32'hBAD0_BAD0;
    tick();
    fpu_done = 1'b0;
    chk("idle_done_busy", {63'd0, busy}, 64'd0);
    issue(2'b10, 5'd4, 5'd5, 5'd13, 32'h4010_0000, 32'h40D0_0000, 1'b0, 5'd0, 32'd0);
    fpu_done = 1'b1;
    tick();
    fpu_done = 1'b0;
    chk("issue_done_ignored", {62'd0, dbg_state}, 64'd2);
    tick();
    chk("still_wait", {62'd0, dbg_state}, 64'd2);
    fpu_done = 1'b1;
    fpu_R = 32'h600D_F00D;
    resp_q.push_back({5'd13, 32'h600D_F00D});
    tick();
    fpu_done = 1'b0;
    chk("late_done_resp", {63'd0, resp_valid}, 64'd1);
    tick();

    // timeout: 8 WAIT cycles then back to IDLE, no write-back
    issue(2'b11, 5'd3, 5'd6, 5'd1, 32'h3E00_0000, 32'h410C_0000, 1'b0, 5'd0, 32'd0);
    tick();
    for (int i = 0; i < 7; i++) begin
      chk("to_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    chk("to_last_wait", {62'd0, dbg_state}, 64'd2);
    chk("to_err_pending", {63'd0, timeout_err}, 64'd0);
    tick();
    chk("to_idle", {63'd0, busy}, 64'd0);
    chk("to_err_set", {63'd0, timeout_err}, 64'd1);
    issue(2'b00, 5'd2, 5'd1, 5'd10, 32'hBEC0_0000, 32'h3F00_0000, 1'b0, 5'd0, 32'd0);
    complete(0, 5'd10, 32'hAAAA_5555, 1'b0, 5'd0, 32'd0);
    chk("to_err_sticky", {63'd0, timeout_err}, 64'd1);

    // load bypass on accept, then load/write-back collision on f3
    issue(2'b00, 5'd1, 5'd4, 5'd3, 32'h4000_0000, 32'h4010_0000, 1'b1, 5'd1, 32'h4000_0000);
    complete(2, 5'd3, 32'h1234_5678, 1'b1, 5'd3, 32'hDEAD_BEEF);
    issue(2'b00, 5'd3, 5'd1, 5'd14, 32'h1234_5678, 32'h4000_0000, 1'b0, 5'd0, 32'd0);
    complete(0, 5'd14, 32'h0BAD_CAFE, 1'b0, 5'd0, 32'd0);

    // back-to-back with req_valid held high
    req_valid = 1'b1;
    req_op = 2'b01;
    req_rs1 = 5'd3;
    req_rs2 = 5'd4;
    req_rd = 5'd11;
    start_q.push_back({2'b01, 32'h1234_5678, 32'h4010_0000});
    n_issued++;
    tick();
    chk("b2b_ready_issue", {63'd0, req_ready}, 64'd0);
    req_op = 2'b10;
    req_rs1 = 5'd4;
    req_rs2 = 5'd5;
    req_rd = 5'd12;
    start_q.push_back({2'b10, 32'h4010_0000, 32'h40D0_0000});
    n_issued++;
    tick();
    chk("b2b_ready_wait", {63'd0, req_ready}, 64'd0);
    fpu_done = 1'b1;
    fpu_R = 32'h1111_0001;
    resp_q.push_back({5'd11, 32'h1111_0001});
    tick();
    fpu_done = 1'b0;
    chk("b2b_ready_write", {63'd0, req_ready}, 64'd0);
    chk("b2b_resp", {63'd0, resp_valid}, 64'd1);
    tick();
    chk("b2b_ready_idle", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_second_op", {62'd0, fpu_op}, 64'd2);
    chk("b2b_second_busy", {63'd0, busy}, 64'd1);
    complete(0, 5'd12, 32'h2222_0002, 1'b0, 5'd0, 32'd0);

    repeat (3) tick();
    chk("start_count", 64'(start_seen), 64'(n_issued));
    chk("start_q_empty", 64'(start_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
